// File: rtl/window_shift_ctrl.sv
// Sequencer streaming BRAM words into lo/hi window registers and stepping the byte-rotation select.
// Optional tail window (lo<=hi, hi cleared) enabled by defining WINDOW_PAD_TAIL_EN.
module window_shift_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              lo_load,
  output logic              lo_src,
  output logic              hi_load,
  output logic              hi_clr,
  output logic [2:0]        sel_mux,
  output logic              win_valid,
  input  logic              win_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_CAP_HI, S_STREAM, S_FETCH, S_DONE, S_PAD
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [1:0]        phase_q, phase_d;
  logic              tail_q, tail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      phase_q <= '0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    phase_d   = phase_q;
    tail_d    = tail_q;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    bram_en   = 1'b0;
    bram_addr = '0;
    lo_load   = 1'b0;
    lo_src    = 1'b0;
    hi_load   = 1'b0;
    hi_clr    = 1'b0;
    sel_mux   = 3'd0;
    win_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = num_words;
          phase_d = 2'd0;
          tail_d  = 1'b0;
`ifdef WINDOW_PAD_TAIL_EN
          state_d = (num_words == '0) ? S_DONE : S_RD_LO;
`else
          state_d = (num_words < ADDR_W'(2)) ? S_DONE : S_RD_LO;
`endif
        end
      end
      S_RD_LO: begin
        bram_en   = 1'b1;
        bram_addr = addr_q;
        addr_d    = addr_q + ADDR_W'(1);
        rem_d     = rem_q - ADDR_W'(1);
        state_d   = S_RD_HI;
      end
      S_RD_HI: begin
        lo_load = 1'b1;
        lo_src  = 1'b0;
`ifdef WINDOW_PAD_TAIL_EN
        // Single-word run: capture it into lo and pad hi with zeros directly.
        if (rem_q == '0) begin
          hi_clr  = 1'b1;
          tail_d  = 1'b1;
          phase_d = 2'd0;
          state_d = S_STREAM;
        end else begin
          bram_en   = 1'b1;
          bram_addr = addr_q;
          addr_d    = addr_q + ADDR_W'(1);
          rem_d     = rem_q - ADDR_W'(1);
          state_d   = S_CAP_HI;
        end
`else
        bram_en   = 1'b1;
        bram_addr = addr_q;
        addr_d    = addr_q + ADDR_W'(1);
        rem_d     = rem_q - ADDR_W'(1);
        state_d   = S_CAP_HI;
`endif
      end
      S_CAP_HI: begin
        hi_load = 1'b1;
        phase_d = 2'd0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        win_valid = 1'b1;
        sel_mux   = {1'b0, phase_q};
        if (win_ready) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            if (rem_q != '0) begin
              state_d = S_FETCH;
            end else begin
`ifdef WINDOW_PAD_TAIL_EN
              state_d = tail_q ? S_DONE : S_PAD;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
      S_FETCH: begin
        bram_en   = 1'b1;
        bram_addr = addr_q;
        lo_load   = 1'b1;
        lo_src    = 1'b1;
        addr_d    = addr_q + ADDR_W'(1);
        rem_d     = rem_q - ADDR_W'(1);
        state_d   = S_CAP_HI;
      end
`ifdef WINDOW_PAD_TAIL_EN
      S_PAD: begin
        lo_load = 1'b1;
        lo_src  = 1'b1;
        hi_clr  = 1'b1;
        tail_d  = 1'b1;
        phase_d = 2'd0;
        state_d = S_STREAM;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_window_shift_ctrl.sv
// Directed self-checking bench for window_shift_ctrl (default build; tail test under WINDOW_PAD_TAIL_EN).
module tb_window_shift_ctrl;

  localparam int ADDR_W = 10;
`ifdef WINDOW_PAD_TAIL_EN
  localparam int TAIL = 4;
`else
  localparam int TAIL = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] num_words = '0;
  logic              busy, done, bram_en, lo_load, lo_src, hi_load, hi_clr, win_valid;
  logic [ADDR_W-1:0] bram_addr;
  logic [2:0]        sel_mux;
  logic              win_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  int rd_q[$];
  int sel_q[$];
  int valid_cnt, hold_err, done_cyc, last_acc, hi_clr_cnt, hi_clr_cyc, hi_clr_bad;
  bit timed_out;

  window_shift_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr),
    .lo_load(lo_load), .lo_src(lo_src), .hi_load(hi_load), .hi_clr(hi_clr),
    .sel_mux(sel_mux), .win_valid(win_valid), .win_ready(win_ready)
  );

  always #5 clk = ~clk;

  task automatic pulse_start(input int b, input int n);
    @(negedge clk);
    base_addr = ADDR_W'(b);
    num_words = ADDR_W'(n);
    start     = 1'b1;
  endtask

  // Observe one run; cycle 0 is the first cycle after start is sampled.
  task automatic run_capture(input int max_cyc, input bit toggle);
    bit prev_stall = 1'b0;
    int prev_sel = 0;
    rd_q.delete();
    sel_q.delete();
    valid_cnt = 0; hold_err = 0; done_cyc = -1; last_acc = -1;
    hi_clr_cnt = 0; hi_clr_cyc = -1; hi_clr_bad = 0;
    timed_out = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      win_ready = toggle ? (c % 2 == 1) : 1'b1;
      if (bram_en) rd_q.push_back(int'(bram_addr));
      if (win_valid) valid_cnt++;
      if (prev_stall && (!win_valid || int'(sel_mux) != prev_sel)) hold_err++;
      if (win_valid && win_ready) begin
        sel_q.push_back(int'(sel_mux));
        last_acc = c;
      end
      if (hi_clr) begin
        hi_clr_cnt++;
        hi_clr_cyc = c;
        if (!(lo_load && lo_src)) hi_clr_bad++;
      end
      prev_stall = win_valid && !win_ready;
      prev_sel   = int'(sel_mux);
      if (done) begin
        done_cyc  = c;
        timed_out = 1'b0;
        break;
      end
    end
    win_ready = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, done, bram_en, bram_addr, lo_load, lo_src, hi_load, hi_clr, sel_mux, win_valid} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%0b done=%0b bram_en=%0b addr=%0h win_valid=%0b sel=%0d, required all 0",
               busy, done, bram_en, bram_addr, win_valid, sel_mux);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy: got %0b required 0", busy);
    end
  endtask

  task automatic test_basic_run;
    pulse_start(12'h010, 3);
    run_capture(100, 1'b0);
    checks++;
    if (timed_out) begin failures++; $display("FAIL basic_timeout: no done within 100 cycles"); end
    checks++;
    if (rd_q.size() != 3) begin
      failures++; $display("FAIL basic_read_count: got %0d required 3", rd_q.size());
    end else for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_q[i] !== 16'h010 + i) begin
        failures++; $display("FAIL basic_read_addr[%0d]: got %0h required %0h", i, rd_q[i], 16'h010 + i);
      end
    end
    checks++;
    if (sel_q.size() != 8 + TAIL) begin
      failures++; $display("FAIL basic_window_count: got %0d required %0d", sel_q.size(), 8 + TAIL);
    end else for (int i = 0; i < sel_q.size(); i++) begin
      checks++;
      if (sel_q[i] !== i % 4) begin
        failures++; $display("FAIL basic_sel[%0d]: got %0d required %0d", i, sel_q[i], i % 4);
      end
    end
    checks++;
    if (done_cyc !== last_acc + 1) begin
      failures++; $display("FAIL basic_done_timing: done at %0d required %0d", done_cyc, last_acc + 1);
    end
`ifndef WINDOW_PAD_TAIL_EN
    checks++;
    if (done_cyc !== 13) begin
      failures++; $display("FAIL basic_throughput: done at cycle %0d required 13", done_cyc);
    end
    checks++;
    if (hi_clr_cnt !== 0) begin
      failures++; $display("FAIL basic_hi_clr: got %0d pulses required 0", hi_clr_cnt);
    end
`endif
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL basic_after_done: busy=%0b done=%0b required 0 0", busy, done);
    end
  endtask

  task automatic test_backpressure;
    pulse_start(12'h010, 3);
    run_capture(200, 1'b1);
    checks++;
    if (timed_out) begin failures++; $display("FAIL bp_timeout: no done within 200 cycles"); end
    checks++;
    if (hold_err !== 0) begin
      failures++; $display("FAIL bp_hold: %0d stall cycles changed sel/valid, required 0", hold_err);
    end
    checks++;
    if (rd_q.size() !== 3) begin
      failures++; $display("FAIL bp_read_count: got %0d required 3", rd_q.size());
    end
    checks++;
    if (sel_q.size() != 8 + TAIL) begin
      failures++; $display("FAIL bp_window_count: got %0d required %0d", sel_q.size(), 8 + TAIL);
    end else for (int i = 0; i < sel_q.size(); i++) begin
      checks++;
      if (sel_q[i] !== i % 4) begin
        failures++; $display("FAIL bp_sel[%0d]: got %0d required %0d", i, sel_q[i], i % 4);
      end
    end
    checks++;
    if (done_cyc !== last_acc + 1) begin
      failures++; $display("FAIL bp_done_timing: done at %0d required %0d", done_cyc, last_acc + 1);
    end
  endtask

  task automatic test_addr_wrap;
    pulse_start(12'h3FF, 2);
    run_capture(100, 1'b0);
    checks++;
    if (rd_q.size() != 2) begin
      failures++; $display("FAIL wrap_read_count: got %0d required 2", rd_q.size());
    end else begin
      checks++;
      if (rd_q[0] !== 12'h3FF || rd_q[1] !== 0) begin
        failures++; $display("FAIL wrap_addr: got %0h,%0h required 3ff,0", rd_q[0], rd_q[1]);
      end
    end
    checks++;
    if (sel_q.size() !== 4 + TAIL) begin
      failures++; $display("FAIL wrap_window_count: got %0d required %0d", sel_q.size(), 4 + TAIL);
    end
  endtask

`ifndef WINDOW_PAD_TAIL_EN
  task automatic test_short_runs;
    for (int n = 0; n < 2; n++) begin
      pulse_start(12'h040, n);
      run_capture(20, 1'b0);
      checks++;
      if (timed_out || done_cyc > 1) begin
        failures++; $display("FAIL short%0d_done: done at cycle %0d required <=1", n, done_cyc);
      end
      checks++;
      if (rd_q.size() !== 0 || valid_cnt !== 0) begin
        failures++; $display("FAIL short%0d_activity: reads=%0d valid=%0d required 0 0", n, rd_q.size(), valid_cnt);
      end
    end
  endtask
`else
  task automatic test_pad_tail;
    pulse_start(12'h080, 2);
    run_capture(100, 1'b0);
    checks++;
    if (sel_q.size() !== 8) begin
      failures++; $display("FAIL pad_window_count: got %0d required 8", sel_q.size());
    end
    checks++;
    if (hi_clr_cnt !== 1 || hi_clr_bad !== 0) begin
      failures++; $display("FAIL pad_hi_clr: pulses=%0d uncoupled=%0d required 1 0", hi_clr_cnt, hi_clr_bad);
    end
    checks++;
    if (hi_clr_cyc !== 7) begin
      failures++; $display("FAIL pad_hi_clr_cycle: got %0d required 7", hi_clr_cyc);
    end
    checks++;
    if (rd_q.size() !== 2) begin
      failures++; $display("FAIL pad_read_count: got %0d required 2", rd_q.size());
    end
    pulse_start(12'h080, 1);
    run_capture(50, 1'b0);
    checks++;
    if (sel_q.size() !== 4 || rd_q.size() !== 1) begin
      failures++; $display("FAIL pad_single: windows=%0d reads=%0d required 4 1", sel_q.size(), rd_q.size());
    end
  endtask
`endif

  task automatic test_midrun_reset;
    int done_seen = 0;
    pulse_start(12'h010, 3);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      win_ready = 1'b1;
      if (done) done_seen++;
      // Re-pulse start while streaming; it must be ignored.
      start = (c == 4);
      if (c == 4) begin
        base_addr = 10'h100;
        num_words = 10'd5;
      end
    end
    start = 1'b0;
    checks++;
    if (win_valid !== 1'b1 || sel_mux !== 3'd2) begin
      failures++; $display("FAIL midrun_ignore_start: valid=%0b sel=%0d required 1 2", win_valid, sel_mux);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bram_en, bram_addr, lo_load, lo_src, hi_load, hi_clr, sel_mux, win_valid} !== '0) begin
      failures++;
      $display("FAIL midrun_reset_outputs: busy=%0b valid=%0b sel=%0d bram_en=%0b required all 0",
               busy, win_valid, sel_mux, bram_en);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++; $display("FAIL midrun_no_done: got %0d pulses required 0", done_seen);
    end
    pulse_start(12'h020, 2);
    run_capture(100, 1'b0);
    checks++;
    if (timed_out || rd_q.size() != 2) begin
      failures++; $display("FAIL rerun_reads: timeout=%0b reads=%0d required 0 2", timed_out, rd_q.size());
    end else begin
      checks++;
      if (rd_q[0] !== 12'h020 || rd_q[1] !== 12'h021) begin
        failures++; $display("FAIL rerun_addr: got %0h,%0h required 20,21", rd_q[0], rd_q[1]);
      end
    end
    checks++;
    if (sel_q.size() !== 4 + TAIL) begin
      failures++; $display("FAIL rerun_window_count: got %0d required %0d", sel_q.size(), 4 + TAIL);
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_backpressure();
    test_addr_wrap();
`ifndef WINDOW_PAD_TAIL_EN
    test_short_runs();
`else
    test_pad_tail();
`endif
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_shift_ctrl.md
Name: window_shift_ctrl

Overview:
- Sequencer for the byte-rotation window datapath.
- Streams a run of 32-bit words from the image BRAM port B into the low-word (bytes o1..o4) and high-word (bytes o5..o8) window registers.
- Steps the 3-bit rotation select so each word pair yields four byte-shifted windows, with a valid/ready handshake to the downstream pixel consumer.
- Sits between the host/frame FSM (start/done) and the BRAM + window registers + rotation mux bank.

Parameters:
- ADDR_W, 10, width of BRAM read address and word count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a run. Sampled only in IDLE.
- base_addr  in  ADDR_W  first word address. Sampled with start.
- num_words  in  ADDR_W  number of words in the run. Sampled with start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of run.
- bram_en  out  1  BRAM port B read enable.
- bram_addr  out  ADDR_W  BRAM port B read address.
- lo_load  out  1  load the low window register at the next edge.
- lo_src  out  1  low-register source: 0 = doutb, 1 = current high register.
- hi_load  out  1  load the high window register from doutb at the next edge.
- hi_clr  out  1  clear the high window register to 0 (optional feature only; otherwise tied 0).
- sel_mux  out  3  rotation select to the mux bank. Values 0..3 only.
- win_valid  out  1  window on the mux outputs is valid.
- win_ready  in  1  consumer accepts the window when win_valid && win_ready.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; internal counters 0. Reset mid-run abandons the run; no done pulse.
- BRAM read latency is fixed at 1: data for an address issued in cycle t is on doutb in cycle t+1 and captured at the end of t+1.
- Internal state:
  - addr_q: next read address, ADDR_W bits; wraps modulo 2^ADDR_W.
  - rem_q: words not yet fetched.
  - phase_q: 2-bit shift counter.
- IDLE:
  - start && num_words>=2 -> RD_LO; busy=1.
  - start && num_words<2 -> DONE. Produces no windows, issues no reads.
  - start outside IDLE is ignored.
- RD_LO: bram_en=1, bram_addr=base -> RD_HI.
- RD_HI: bram_en=1, bram_addr=base+1; lo_load=1, lo_src=0 -> CAP_HI.
- CAP_HI: hi_load=1; phase=0 -> STREAM.
- STREAM:
  - win_valid=1; sel_mux=phase_q, held stable while win_ready=0.
  - On accept with phase_q<3: phase_q+1.
  - On accept with phase_q==3: -> FETCH if words remain, else -> DONE.
- FETCH: bram_en=1, bram_addr=addr_q; lo_load=1, lo_src=1 (lo<=hi) -> CAP_HI.
- DONE: done=1 for one cycle; busy=0 from next cycle -> IDLE.
- Output count: exactly 4*(num_words-1) windows.
  - Pair k = words base+k and base+k+1, for k = 0..num_words-2.
  - sel order within each pair is 0,1,2,3.
- win_valid is 0 in every state except STREAM.
- bram_en is high only in RD_LO, RD_HI and FETCH.
- Address wrap: base_addr=2^ADDR_W-1 fetches 2^ADDR_W-1, then 0, 1, ...
- No bubbles beyond 2 cycles (FETCH, CAP_HI) between pairs when win_ready is held high.
- Sustained throughput: 4 windows per 6 cycles.

Optional Feature:
- Macro: WINDOW_PAD_TAIL_EN.
- Defined:
  - After the last pair completes, a tail window is emitted: lo<=hi via lo_load/lo_src=1, plus hi_clr=1, in a PAD state (no BRAM read). It then streams sel 0..3.
  - Total windows = 4*num_words for num_words>=1.
  - num_words==1 performs RD_LO, RD_HI-style capture of the single word, then PAD.
  - num_words==0 -> DONE immediately.
- Not defined: PAD state absent; hi_clr tied 0; window count 4*(num_words-1).

Test Plan:
- base=0x010, num_words=3, win_ready=1:
  - reads 0x010, 0x011, 0x012;
  - 8 windows with sel 0,1,2,3,0,1,2,3;
  - done 1 cycle after the 8th accept; busy low afterwards.
- Same run with win_ready toggling 1,0 every cycle: sel_mux and win_valid are held during stalls; same 8-window sequence; no extra BRAM reads.
- base=0x3FF (ADDR_W=10), num_words=2: bram_addr sequence 0x3FF, 0x000; 4 windows.
- num_words=1 and num_words=0 (feature off): no bram_en, no win_valid, done pulse within 2 cycles of start.
- start re-pulsed mid-run, then rst_n dropped during STREAM: the start is ignored; on reset all outputs 0 immediately, no done; a fresh start after release runs normally.
- WINDOW_PAD_TAIL_EN defined, num_words=2:
  - 8 windows;
  - hi_clr asserted exactly once, coincident with lo_load && lo_src=1 before the last 4 windows.
